// File: rtl/fwd_pkg.sv
// Shared types for the forwarding result pipe: stage record, empty-stage constant, issue helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fwd_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // One pipeline slot as seen by the forwarding unit and the register file.
    typedef struct packed {
        logic                  write;
        logic [REG_ADDR_W-1:0] addr;
        logic                  mem;
        logic [XLEN-1:0]       data;
    } fwd_stage_t;

    // Empty slot: no write, not a load, zero data.
    localparam fwd_stage_t FWD_BUBBLE = '0;

    // Entry for a freshly accepted instruction; x0 destinations never forward.
    function automatic fwd_stage_t fwd_issue_entry(
        input logic                  wen,
        input logic [REG_ADDR_W-1:0] rd,
        input logic                  is_load
    );
        fwd_stage_t e;
        e       = FWD_BUBBLE;
        e.write = wen && (rd != '0);
        e.addr  = rd;
        e.mem   = is_load;
        return e;
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline slot register holding a fwd_stage_t.
// Latency: 1 cycle from i_d to o_q when i_en is high.
// Backpressure: i_en low retains the current contents.
module fwd_stage_reg
    import fwd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  fwd_stage_t i_d,
    output fwd_stage_t o_q
);

    fwd_stage_t r_q;

    // Capture the next slot contents whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= FWD_BUBBLE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fwd_result_pipe.sv
// Tracks in-flight destinations through EX/MEM/WB for operand forwarding and drives the RF write port.
// Latency: issue to wb_en is 3 advancing edges; each hold cycle adds one.
// Backpressure: hold freezes every stage; bubble/flush insert an empty P1. FWD_PIPE_STATS_EN adds counters.
module fwd_result_pipe
    import fwd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic                  issue_wen,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_is_load,
    input  logic                  bubble,
    input  logic                  flush,
    input  logic                  hold,
    input  logic [XLEN-1:0]       ex_result,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  prev1_write,
    output logic [REG_ADDR_W-1:0] prev1_write_addr,
    output logic                  prev1_mem,
    output logic                  prev2_write,
    output logic [REG_ADDR_W-1:0] prev2_write_addr,
    output logic                  prev2_mem,
    output logic                  prev3_write,
    output logic [REG_ADDR_W-1:0] prev3_write_addr,
    output logic                  prev3_mem,
    output logic [XLEN-1:0]       prev2_data,
    output logic [XLEN-1:0]       prev3_data,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]       wb_data
`ifdef FWD_PIPE_STATS_EN
    ,
    output logic [31:0]           stat_bubbles,
    output logic [31:0]           stat_retired
`endif
);

    logic       w_adv;
    fwd_stage_t w_p1_d, w_p2_d, w_p3_d;
    fwd_stage_t w_p1_q, w_p2_q, w_p3_q;

    assign w_adv = ~hold;

    // P1 takes the issued instruction only when neither a squash nor a load-use stall applies.
    always_comb begin
        w_p1_d = FWD_BUBBLE;
        if (!flush && !bubble && issue_valid) begin
            w_p1_d = fwd_issue_entry(issue_wen, issue_rd, issue_is_load);
        end
    end

    // P2 picks up the ALU result; non-writing slots keep zero data so empty slots stay clean.
    always_comb begin
        w_p2_d      = w_p1_q;
        w_p2_d.data = w_p1_q.write ? ex_result : '0;
    end

    // P3 holds the final value: load data for loads, otherwise the ALU result carried from P2.
    always_comb begin
        w_p3_d = w_p2_q;
        if (!w_p2_q.write) begin
            w_p3_d.data = '0;
        end else if (w_p2_q.mem) begin
            w_p3_d.data = mem_rdata;
        end
    end

    fwd_stage_reg u_p1 (.clk(clk), .rst_n(rst_n), .i_en(w_adv), .i_d(w_p1_d), .o_q(w_p1_q));
    fwd_stage_reg u_p2 (.clk(clk), .rst_n(rst_n), .i_en(w_adv), .i_d(w_p2_d), .o_q(w_p2_q));
    fwd_stage_reg u_p3 (.clk(clk), .rst_n(rst_n), .i_en(w_adv), .i_d(w_p3_d), .o_q(w_p3_q));

    // A squashed instruction is consumed; a stalled one is refused so decode replays it.
    assign issue_ready = w_adv & (flush | (~bubble & issue_valid));

    assign prev1_write      = w_p1_q.write;
    assign prev1_write_addr = w_p1_q.addr;
    assign prev1_mem        = w_p1_q.mem;
    assign prev2_write      = w_p2_q.write;
    assign prev2_write_addr = w_p2_q.addr;
    assign prev2_mem        = w_p2_q.mem;
    assign prev3_write      = w_p3_q.write;
    assign prev3_write_addr = w_p3_q.addr;
    assign prev3_mem        = w_p3_q.mem;
    assign prev2_data       = w_p2_q.data;
    assign prev3_data       = w_p3_q.data;

    // The P3 entry stays put under hold, so its write is masked to commit exactly once.
    assign wb_en   = w_p3_q.write & w_adv;
    assign wb_addr = w_p3_q.addr;
    assign wb_data = w_p3_q.data;

`ifdef FWD_PIPE_STATS_EN
    logic [31:0] r_stat_bubbles;
    logic [31:0] r_stat_retired;

    // Count load-use stalls that actually took effect and register-file commits; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_bubbles <= '0;
            r_stat_retired <= '0;
        end else begin
            if (w_adv && bubble && !flush) begin
                r_stat_bubbles <= r_stat_bubbles + 32'd1;
            end
            if (wb_en) begin
                r_stat_retired <= r_stat_retired + 32'd1;
            end
        end
    end

    assign stat_bubbles = r_stat_bubbles;
    assign stat_retired = r_stat_retired;
`endif

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Directed and randomized checks of fwd_result_pipe against a slot-array reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fwd_result_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_ready, issue_wen, issue_is_load;
    logic [4:0]  issue_rd;
    logic        bubble, flush, hold;
    logic [31:0] ex_result, mem_rdata;
    logic        prev1_write, prev2_write, prev3_write;
    logic [4:0]  prev1_write_addr, prev2_write_addr, prev3_write_addr;
    logic        prev1_mem, prev2_mem, prev3_mem;
    logic [31:0] prev2_data, prev3_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
`ifdef FWD_PIPE_STATS_EN
    logic [31:0] stat_bubbles, stat_retired;
`endif

    fwd_result_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .issue_is_load(issue_is_load),
        .bubble(bubble), .flush(flush), .hold(hold),
        .ex_result(ex_result), .mem_rdata(mem_rdata),
        .prev1_write(prev1_write), .prev1_write_addr(prev1_write_addr), .prev1_mem(prev1_mem),
        .prev2_write(prev2_write), .prev2_write_addr(prev2_write_addr), .prev2_mem(prev2_mem),
        .prev3_write(prev3_write), .prev3_write_addr(prev3_write_addr), .prev3_mem(prev3_mem),
        .prev2_data(prev2_data), .prev3_data(prev3_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
`ifdef FWD_PIPE_STATS_EN
        , .stat_bubbles(stat_bubbles), .stat_retired(stat_retired)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: three slots, index 1 = youngest.
    typedef struct {
        bit          w;
        logic [4:0]  a;
        bit          m;
        logic [31:0] d;
    } slot_t;

    slot_t       m[1:3];
    int unsigned m_bub, m_ret;
    int          n_pass, n_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int s = 1; s <= 3; s++) begin
            m[s].w = 1'b0; m[s].a = '0; m[s].m = 1'b0; m[s].d = '0;
        end
        m_bub = 0;
        m_ret = 0;
    endtask

    // Apply one clock edge using the inputs that were present at that edge.
    task automatic model_edge();
        slot_t n1, n2, n3;
        if (hold) return;
        if (bubble && !flush) m_bub++;
        if (m[3].w) m_ret++;
        n3 = m[2];
        n3.d = !m[2].w ? 32'd0 : (m[2].m ? mem_rdata : m[2].d);
        n2 = m[1];
        n2.d = m[1].w ? ex_result : 32'd0;
        n1.w = 1'b0; n1.a = '0; n1.m = 1'b0; n1.d = '0;
        if (issue_valid && !flush && !bubble) begin
            n1.w = issue_wen && (issue_rd != 5'd0);
            n1.a = issue_rd;
            n1.m = issue_is_load;
        end
        m[1] = n1; m[2] = n2; m[3] = n3;
    endtask

    task automatic check_comb();
        chk("issue_ready", issue_ready, !hold && (flush || (!bubble && issue_valid)));
        chk("wb_en", wb_en, m[3].w && !hold);
    endtask

    task automatic check_regs();
        chk("prev1_write", prev1_write, m[1].w);
        chk("prev1_addr",  prev1_write_addr, m[1].a);
        chk("prev1_mem",   prev1_mem, m[1].m);
        chk("prev2_write", prev2_write, m[2].w);
        chk("prev2_addr",  prev2_write_addr, m[2].a);
        chk("prev2_mem",   prev2_mem, m[2].m);
        chk("prev2_data",  prev2_data, m[2].d);
        chk("prev3_write", prev3_write, m[3].w);
        chk("prev3_addr",  prev3_write_addr, m[3].a);
        chk("prev3_mem",   prev3_mem, m[3].m);
        chk("prev3_data",  prev3_data, m[3].d);
        chk("wb_addr",     wb_addr, m[3].a);
        chk("wb_data",     wb_data, m[3].d);
`ifdef FWD_PIPE_STATS_EN
        chk("stat_bubbles", stat_bubbles, m_bub);
        chk("stat_retired", stat_retired, m_ret);
`endif
    endtask

    // Inputs are set just after a rising edge; this checks, takes the edge, and checks again.
    task automatic cycle();
        #1;
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic idle();
        issue_valid = 0; issue_wen = 0; issue_rd = '0; issue_is_load = 0;
        bubble = 0; flush = 0; hold = 0;
    endtask

    task automatic issue(input logic wen, input logic [4:0] rd, input logic ld);
        issue_valid = 1; issue_wen = wen; issue_rd = rd; issue_is_load = ld;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        idle();
        ex_result = '0;
        mem_rdata = '0;
        rst_n = 0;
        model_reset();
        #2;
        check_comb();
        check_regs();
        #1 rst_n = 1;

        // 1: ALU write to x5 flows through to the write port.
        issue(1, 5'd5, 0);
        ex_result = 32'h11;
        cycle();
        chk("t1_p1_write", prev1_write, 1);
        chk("t1_p1_addr", prev1_write_addr, 5);
        idle();
        cycle();
        chk("t1_p2_data", prev2_data, 32'h11);
        cycle();
        chk("t1_wb_en", wb_en, 1);
        chk("t1_wb_addr", wb_addr, 5);
        chk("t1_wb_data", wb_data, 32'h11);
        cycle();

        // 2: load to x7 followed by a dependent instruction stalled one cycle.
        issue(1, 5'd7, 1);
        ex_result = 32'h40;
        cycle();
        issue(1, 5'd8, 0);
        bubble = 1;
        #1 chk("t2_ready_stall", issue_ready, 0);
        cycle();
        chk("t2_p1_empty", prev1_write, 0);
        chk("t2_p2_mem", prev2_mem, 1);
        bubble = 0;
        mem_rdata = 32'hCAFE;
        #1 chk("t2_ready_replay", issue_ready, 1);
        cycle();
        chk("t2_p1_replayed", prev1_write_addr, 8);
        chk("t2_wb_data", wb_data, 32'hCAFE);
        idle();
        cycle();
        cycle();

        // 3: writes to x0 never forward or commit.
        issue(1, 5'd0, 0);
        ex_result = 32'h99;
        cycle();
        chk("t3_p1_write", prev1_write, 0);
        idle();
        cycle();
        chk("t3_p2_write", prev2_write, 0);
        cycle();
        chk("t3_p3_write", prev3_write, 0);
        chk("t3_wb_en", wb_en, 0);

        // 4: full pipe frozen by hold for two cycles, then the oldest entry retires once.
        issue(1, 5'd1, 0); ex_result = 32'hA0; cycle();
        issue(1, 5'd2, 0); ex_result = 32'hA1; cycle();
        issue(1, 5'd3, 0); ex_result = 32'hA2; cycle();
        issue(1, 5'd9, 0);
        hold = 1;
        #1 chk("t4_wb_en_hold", wb_en, 0);
        cycle();
        chk("t4_p3_frozen", prev3_write_addr, 1);
        cycle();
        chk("t4_p1_frozen", prev1_write_addr, 3);
        idle();
        #1 chk("t4_wb_en_release", wb_en, 1);
        cycle();
        chk("t4_next_retire", wb_addr, 2);
        cycle();
        cycle();

        // 5: flush beats bubble; the squashed instruction is consumed.
        issue(1, 5'd4, 0);
        flush = 1;
        bubble = 1;
        #1 chk("t5_ready", issue_ready, 1);
        cycle();
        chk("t5_p1_empty", prev1_write, 0);
        idle();

        // 6: asynchronous reset while P2 holds a load.
        issue(1, 5'd6, 1); cycle();
        idle(); cycle();
        chk("t6_p2_load", prev2_mem, 1);
        rst_n = 0;
        #1;
        model_reset();
        chk("t6_p1_write", prev1_write, 0);
        chk("t6_p2_write", prev2_write, 0);
        chk("t6_p2_mem", prev2_mem, 0);
        chk("t6_p3_write", prev3_write, 0);
        chk("t6_wb_en", wb_en, 0);
        check_regs();
        #2 rst_n = 1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_wen     = $urandom_range(0, 1);
            issue_rd      = 5'($urandom_range(0, 31));
            issue_is_load = $urandom_range(0, 1);
            bubble        = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            hold          = ($urandom_range(0, 5) == 0);
            ex_result     = $urandom;
            mem_rdata     = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
